// File: rtl/move_writer.sv
// move_writer: validates one ultimate tic-tac-toe move and performs its single
// write into ram_board. It then works out which macro board the opponent is
// forced into. It is the only driver of the ram_board write/address inputs.
module move_writer #(
    parameter int MAX_MOVES = 81
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] macro_in,
    input  logic [3:0] micro_in,
    input  logic [1:0] q,
    input  logic [1:0] state,
    output logic       we,
    output logic [1:0] data,
    output logic [3:0] addr_macro,
    output logic [3:0] addr_micro,
    output logic [1:0] jogador,
    output logic [3:0] next_macro,
    output logic [6:0] moves,
    output logic       busy,
    output logic       done,
    output logic       invalid
);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        READ,
        EVAL,
        WRITE,
        SETTLE,
        NEXT,
        DONE,
        ERR
    } fsm_t;

    localparam logic [6:0] MOVES_CAP = 7'(MAX_MOVES);
    localparam logic [1:0] PLAYER_1  = 2'b01;
    localparam logic [1:0] PLAYER_2  = 2'b10;
    localparam logic [1:0] CELL_FREE = 2'b00;
    localparam logic [1:0] BOARD_OPEN = 2'b00;

    fsm_t       fsm_state;
    fsm_t       fsm_next;
    logic [3:0] m_r;
    logic [3:0] u_r;
    logic       coord_bad;
    logic       forced_bad;
    logic       cell_ok;

    // Board and cell numbers are 1..9; zero and 10..15 are never legal.
    function automatic logic in_range(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd9);
    endfunction

    // Rule checks used by the next-state logic, kept separate so they read
    // like the rules of the game.
    always_comb begin
        coord_bad  = !in_range(m_r) || !in_range(u_r);
        forced_bad = (next_macro != 4'd0) && (m_r != next_macro);
        cell_ok    = (q == CELL_FREE) && (state == BOARD_OPEN);
    end

    // FSM state register; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    // Latch the requested coordinates only when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_r <= 4'd0;
            u_r <= 4'd0;
        end else if ((fsm_state == IDLE) && jogar) begin
            m_r <= macro_in;
            u_r <= micro_in;
        end
    end

    // Game bookkeeping: forced board, player to move and move counter only
    // change on the accepted path, so a rejection leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            jogador    <= PLAYER_1;
            next_macro <= 4'd0;
            moves      <= 7'd0;
        end else begin
            case (fsm_state)
                NEXT: begin
                    next_macro <= (state == BOARD_OPEN) ? u_r : 4'd0;
                end
                DONE: begin
                    jogador <= (jogador == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                    if (moves < MOVES_CAP) begin
                        moves <= moves + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic: range/forced checks first, then the memory-based
    // checks once the registered read has returned.
    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            IDLE:    fsm_next = jogar ? CHECK : IDLE;
            CHECK:   fsm_next = (coord_bad || forced_bad) ? ERR : READ;
            READ:    fsm_next = EVAL;
            EVAL:    fsm_next = cell_ok ? WRITE : ERR;
            WRITE:   fsm_next = SETTLE;
            SETTLE:  fsm_next = NEXT;
            NEXT:    fsm_next = DONE;
            DONE:    fsm_next = IDLE;
            ERR:     fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Output decode: the address follows the request while validating and
    // writing, then points at the target board so its state can be sampled.
    always_comb begin
        we         = 1'b0;
        data       = 2'b00;
        addr_macro = 4'd0;
        addr_micro = 4'd0;
        done       = 1'b0;
        invalid    = 1'b0;
        busy       = (fsm_state != IDLE);
        case (fsm_state)
            CHECK, READ, EVAL: begin
                addr_macro = m_r;
                addr_micro = u_r;
            end
            WRITE: begin
                addr_macro = m_r;
                addr_micro = u_r;
                we         = 1'b1;
                data       = jogador;
            end
            SETTLE, NEXT: begin
                addr_macro = u_r;
                addr_micro = 4'd0;
            end
            DONE: begin
                addr_macro = u_r;
                addr_micro = 4'd0;
                done       = 1'b1;
            end
            ERR: begin
                addr_macro = m_r;
                addr_micro = u_r;
                invalid    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_move_writer.sv
// tb_move_writer: directed bench for move_writer with a behavioural
// ram_board (registered cell read and board state) attached.
module tb_move_writer;

    logic       clk;
    logic       reset;
    logic       jogar;
    logic [3:0] macro_in;
    logic [3:0] micro_in;
    logic [1:0] q;
    logic [1:0] state;
    logic       we;
    logic [1:0] data;
    logic [3:0] addr_macro;
    logic [3:0] addr_micro;
    logic [1:0] jogador;
    logic [3:0] next_macro;
    logic [6:0] moves;
    logic       busy;
    logic       done;
    logic       invalid;

    int checks   = 0;
    int failures = 0;

    // Observations recorded by play_move for the scenario tasks to compare.
    int         we_count;
    int         we_cycle;
    int         done_cycle;
    int         inv_cycle;
    int         busy_bad;
    int         end_busy;
    logic [1:0] we_data;
    logic [3:0] we_am;
    logic [3:0] we_au;
    logic [3:0] settle_am;
    logic [3:0] settle_au;

    logic       clear_ram;
    logic [1:0] cells [0:15][0:15];

    move_writer #(.MAX_MOVES(81)) dut (
        .clk        (clk),
        .reset      (reset),
        .jogar      (jogar),
        .macro_in   (macro_in),
        .micro_in   (micro_in),
        .q          (q),
        .state      (state),
        .we         (we),
        .data       (data),
        .addr_macro (addr_macro),
        .addr_micro (addr_micro),
        .jogador    (jogador),
        .next_macro (next_macro),
        .moves      (moves),
        .busy       (busy),
        .done       (done),
        .invalid    (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board state of macro board m: 01/10 when that player has three in a
    // row, 11 when every cell is filled, otherwise 00.
    function automatic logic [1:0] board_state(input logic [3:0] m);
        logic [1:0] b [1:9];
        logic [1:0] pp;
        logic       full;
        if (m < 4'd1 || m > 4'd9) return 2'b00;
        for (int i = 1; i <= 9; i++) b[i] = cells[m][i];
        for (int p = 1; p <= 2; p++) begin
            pp = 2'(p);
            if ((b[1] == pp && b[2] == pp && b[3] == pp) ||
                (b[4] == pp && b[5] == pp && b[6] == pp) ||
                (b[7] == pp && b[8] == pp && b[9] == pp) ||
                (b[1] == pp && b[4] == pp && b[7] == pp) ||
                (b[2] == pp && b[5] == pp && b[8] == pp) ||
                (b[3] == pp && b[6] == pp && b[9] == pp) ||
                (b[1] == pp && b[5] == pp && b[9] == pp) ||
                (b[3] == pp && b[5] == pp && b[7] == pp))
                return pp;
        end
        full = 1'b1;
        for (int i = 1; i <= 9; i++) if (b[i] == 2'b00) full = 1'b0;
        return full ? 2'b11 : 2'b00;
    endfunction

    // ram_board model: write on we, registered cell and board-state reads.
    always @(posedge clk) begin
        if (clear_ram) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    cells[i][j] <= 2'b00;
            q     <= 2'b00;
            state <= 2'b00;
        end else begin
            if (we) cells[addr_macro][addr_micro] <= data;
            q     <= cells[addr_macro][addr_micro];
            state <= board_state(addr_macro);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Synchronous reset plus a cleared board; ends on a negedge with DUT idle.
    task automatic do_reset();
        reset     = 1'b1;
        clear_ram = 1'b1;
        jogar     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        clear_ram = 1'b0;
    endtask

    // Issue one request and record what happens cycle by cycle (cycle 0 is
    // the edge that samples jogar); stops after done/invalid or 12 cycles.
    task automatic play_move(input logic [3:0] m, input logic [3:0] u);
        bit ended;
        we_count   = 0;
        we_cycle   = -1;
        done_cycle = -1;
        inv_cycle  = -1;
        busy_bad   = 0;
        we_data    = 2'b00;
        we_am      = 4'd0;
        we_au      = 4'd0;
        settle_am  = 4'hf;
        settle_au  = 4'hf;
        ended      = 1'b0;
        jogar      = 1'b1;
        macro_in   = m;
        micro_in   = u;
        @(negedge clk);
        jogar = 1'b0;
        for (int k = 1; k <= 12 && !ended; k++) begin
            if (we) begin
                we_count++;
                we_cycle = k;
                we_data  = data;
                we_am    = addr_macro;
                we_au    = addr_micro;
            end
            if (k == 5) begin
                settle_am = addr_macro;
                settle_au = addr_micro;
            end
            if (!busy) busy_bad = 1;
            if (done) done_cycle = k;
            if (invalid) inv_cycle = k;
            if (done || invalid) ended = 1'b1;
            @(negedge clk);
        end
        end_busy = int'(busy);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({we, data, addr_macro, addr_micro, next_macro, moves, busy, done, invalid} !== 27'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {we, data, addr_macro, addr_micro, next_macro, moves, busy, done, invalid});
        end
        checks++;
        if (jogador !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_jogador got=%b exp=01", jogador);
        end
    endtask

    task automatic test_first_move();
        play_move(4'd2, 4'd1);
        checks++;
        if (we_count !== 1 || we_cycle !== 4) begin
            failures++;
            $display("[TB] FAIL first_we count=%0d cycle=%0d exp count=1 cycle=4", we_count, we_cycle);
        end
        checks++;
        if ({we_data, we_am, we_au} !== {2'b01, 4'd2, 4'd1}) begin
            failures++;
            $display("[TB] FAIL first_write data=%b addr=%0d/%0d exp 01 at 2/1", we_data, we_am, we_au);
        end
        checks++;
        if (settle_am !== 4'd1 || settle_au !== 4'd0) begin
            failures++;
            $display("[TB] FAIL first_settle_addr got=%0d/%0d exp=1/0", settle_am, settle_au);
        end
        checks++;
        if (done_cycle !== 7 || inv_cycle !== -1) begin
            failures++;
            $display("[TB] FAIL first_done done=%0d inv=%0d exp done=7 inv=-1", done_cycle, inv_cycle);
        end
        checks++;
        if (busy_bad !== 0 || end_busy !== 0) begin
            failures++;
            $display("[TB] FAIL first_busy gap=%0d after=%0d exp 0/0", busy_bad, end_busy);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b10, 4'd1, 7'd1}) begin
            failures++;
            $display("[TB] FAIL first_state jog=%b next=%0d moves=%0d exp 10/1/1", jogador, next_macro, moves);
        end
    endtask

    task automatic test_forced_macro();
        play_move(4'd2, 4'd1);
        checks++;
        if (inv_cycle !== 2 || we_count !== 0 || done_cycle !== -1) begin
            failures++;
            $display("[TB] FAIL forced_reject inv=%0d we=%0d done=%0d exp 2/0/-1", inv_cycle, we_count, done_cycle);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b10, 4'd1, 7'd1}) begin
            failures++;
            $display("[TB] FAIL forced_unchanged jog=%b next=%0d moves=%0d exp 10/1/1", jogador, next_macro, moves);
        end
        play_move(4'd1, 4'd1);
        checks++;
        if (we_cycle !== 4 || we_data !== 2'b10 || done_cycle !== 7) begin
            failures++;
            $display("[TB] FAIL forced_accept we=%0d data=%b done=%0d exp 4/10/7", we_cycle, we_data, done_cycle);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b01, 4'd1, 7'd2}) begin
            failures++;
            $display("[TB] FAIL forced_after jog=%b next=%0d moves=%0d exp 01/1/2", jogador, next_macro, moves);
        end
    endtask

    task automatic test_occupied();
        play_move(4'd1, 4'd5);
        play_move(4'd5, 4'd1);
        checks++;
        if ({jogador, next_macro, moves} !== {2'b01, 4'd1, 7'd4}) begin
            failures++;
            $display("[TB] FAIL occ_setup jog=%b next=%0d moves=%0d exp 01/1/4", jogador, next_macro, moves);
        end
        play_move(4'd1, 4'd5);
        checks++;
        if (inv_cycle !== 4 || we_count !== 0 || done_cycle !== -1) begin
            failures++;
            $display("[TB] FAIL occ_reject inv=%0d we=%0d done=%0d exp 4/0/-1", inv_cycle, we_count, done_cycle);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b01, 4'd1, 7'd4}) begin
            failures++;
            $display("[TB] FAIL occ_unchanged jog=%b next=%0d moves=%0d exp 01/1/4", jogador, next_macro, moves);
        end
    endtask

    task automatic test_range();
        logic [3:0] bad_m [4];
        logic [3:0] bad_u [4];
        bad_m = '{4'd0, 4'd10, 4'd5, 4'd5};
        bad_u = '{4'd5, 4'd5, 4'd0, 4'd10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            play_move(bad_m[i], bad_u[i]);
            checks++;
            if (inv_cycle !== 2 || we_count !== 0) begin
                failures++;
                $display("[TB] FAIL range_%0d_%0d inv=%0d we=%0d exp 2/0", bad_m[i], bad_u[i], inv_cycle, we_count);
            end
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b01, 4'd0, 7'd0}) begin
            failures++;
            $display("[TB] FAIL range_unchanged jog=%b next=%0d moves=%0d exp 01/0/0", jogador, next_macro, moves);
        end
        play_move(4'd9, 4'd9);
        checks++;
        if (done_cycle !== 7 || we_am !== 4'd9 || we_au !== 4'd9 || next_macro !== 4'd9) begin
            failures++;
            $display("[TB] FAIL range_edge_9_9 done=%0d addr=%0d/%0d next=%0d exp 7 9/9 9",
                     done_cycle, we_am, we_au, next_macro);
        end
    endtask

    task automatic test_closed_target();
        logic [3:0] tm [12];
        logic [3:0] tu [12];
        logic [3:0] tn [12];
        tm = '{4'd2, 4'd1, 4'd2, 4'd2, 4'd4, 4'd2, 4'd8, 4'd2, 4'd9, 4'd5, 4'd2, 4'd3};
        tu = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd2, 4'd8, 4'd2, 4'd9, 4'd5, 4'd2, 4'd3, 4'd2};
        tn = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd2, 4'd8, 4'd2, 4'd9, 4'd5, 4'd2, 4'd3, 4'd0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            play_move(tm[i], tu[i]);
            checks++;
            if (done_cycle !== 7 || next_macro !== tn[i]) begin
                failures++;
                $display("[TB] FAIL closed_step%0d done=%0d next=%0d exp 7/%0d", i + 1, done_cycle, next_macro, tn[i]);
            end
        end
        checks++;
        if (moves !== 7'd12 || jogador !== 2'b01) begin
            failures++;
            $display("[TB] FAIL closed_count moves=%0d jog=%b exp 12/01", moves, jogador);
        end
        play_move(4'd2, 4'd7);
        checks++;
        if (inv_cycle !== 4 || we_count !== 0) begin
            failures++;
            $display("[TB] FAIL closed_board_reject inv=%0d we=%0d exp 4/0", inv_cycle, we_count);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b01, 4'd0, 7'd12}) begin
            failures++;
            $display("[TB] FAIL closed_unchanged jog=%b next=%0d moves=%0d exp 01/0/12", jogador, next_macro, moves);
        end
    endtask

    task automatic test_back_to_back();
        int  busy8;
        bit  ended;
        do_reset();
        we_count  = 0;
        we_cycle  = -1;
        done_cycle = -1;
        inv_cycle = -1;
        busy8     = -1;
        ended     = 1'b0;
        jogar     = 1'b1;
        macro_in  = 4'd5;
        micro_in  = 4'd5;
        @(negedge clk);
        for (int k = 1; k <= 16 && !ended; k++) begin
            if (we) begin
                we_count++;
                we_cycle = k;
            end
            if (k == 8) busy8 = int'(busy);
            if (done) done_cycle = k;
            if (invalid) begin
                inv_cycle = k;
                jogar     = 1'b0;
                ended     = 1'b1;
            end
            @(negedge clk);
        end
        end_busy = int'(busy);
        jogar = 1'b0;
        checks++;
        if (we_count !== 1 || we_cycle !== 4 || done_cycle !== 7) begin
            failures++;
            $display("[TB] FAIL b2b_first we=%0d@%0d done=%0d exp 1@4 done=7", we_count, we_cycle, done_cycle);
        end
        checks++;
        if (busy8 !== 0 || inv_cycle !== 12 || end_busy !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_second busy8=%0d inv=%0d after=%0d exp 0/12/0", busy8, inv_cycle, end_busy);
        end
        checks++;
        if ({jogador, next_macro, moves} !== {2'b10, 4'd5, 7'd1}) begin
            failures++;
            $display("[TB] FAIL b2b_state jog=%b next=%0d moves=%0d exp 10/5/1", jogador, next_macro, moves);
        end
    endtask

    task automatic test_reset_with_jogar();
        reset    = 1'b1;
        jogar    = 1'b1;
        macro_in = 4'd1;
        micro_in = 4'd1;
        @(negedge clk);
        reset = 1'b0;
        jogar = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || moves !== 7'd0 || jogador !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_jogar busy=%b moves=%0d jog=%b exp 0/0/01", busy, moves, jogador);
        end
    endtask

    task automatic test_reset_during_write();
        bit saw_we;
        play_move(4'd2, 4'd1);
        saw_we   = 1'b0;
        jogar    = 1'b1;
        macro_in = 4'd1;
        micro_in = 4'd3;
        @(negedge clk);
        jogar = 1'b0;
        for (int k = 1; k <= 8 && !saw_we; k++) begin
            if (we) saw_we = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (saw_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_write_reach saw_we=%b exp 1", saw_we);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({we, data, addr_macro, addr_micro, next_macro, moves, busy, done, invalid} !== 27'd0
            || jogador !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rst_write_outputs got=%h jog=%b exp 0/01",
                     {we, data, addr_macro, addr_micro, next_macro, moves, busy, done, invalid}, jogador);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_write_dropped busy=%b we=%b exp 0/0", busy, we);
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear_ram = 1'b1;
        jogar     = 1'b0;
        macro_in  = 4'd0;
        micro_in  = 4'd0;
        test_reset();
        test_first_move();
        test_forced_macro();
        test_occupied();
        test_range();
        test_closed_target();
        test_back_to_back();
        test_reset_with_jogar();
        test_reset_during_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_writer.md
# move_writer

Upstream move controller for the ultimate tic-tac-toe board memory (`ram_board`). It accepts a player's move request as a macro/micro coordinate pair and validates it against the range rules, the forced-macro rule, cell occupancy and the macro-board state. It then issues exactly one write of the current player's mark into `ram_board` and computes the macro board the opponent must play next. It is the only block that drives `ram_board`'s `we`/`data`/`addr_*` inputs.

## Interface
Parameters:
- `MAX_MOVES`, default 81: saturation value of the move counter.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `jogar` in 1: move request, sampled only in IDLE.
- `macro_in` in 4: requested macro board, valid range 1..9.
- `micro_in` in 4: requested cell within that board, valid range 1..9.
- `q` in 2: `ram_board` read data (00 empty, 01 player 1, 10 player 2).
- `state` in 2: `ram_board` state of board `addr_macro` (00 open, 01 won by P1, 10 won by P2, 11 full/draw).
- `we` out 1: `ram_board` write enable.
- `data` out 2: `ram_board` write data.
- `addr_macro` out 4: `ram_board` macro address.
- `addr_micro` out 4: `ram_board` micro address.
- `jogador` out 2: player to move (01 or 10).
- `next_macro` out 4: forced board for the next move; 0000 means free choice.
- `moves` out 7: count of accepted moves.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when a move is accepted.
- `invalid` out 1: one-cycle pulse when a move is rejected.

## Operation
- Clock and reset: one clock domain. Reset is synchronous and active-high: `clk` and `reset`.
- FSM states: IDLE, CHECK, READ, EVAL, WRITE, SETTLE, NEXT, DONE, ERR.
- IDLE: when `jogar`=1, latch `macro_in`/`micro_in` into `m_r`/`u_r` and go to CHECK. `jogar` in any other state is ignored; no queuing.
- CHECK: reject (go to ERR) if `m_r` or `u_r` is outside 1..9, or if `next_macro`≠0 and `m_r`≠`next_macro`. Otherwise go to READ.
- READ: drive `addr_macro`=`m_r`, `addr_micro`=`u_r`. One wait cycle covers `ram_board`'s registered read.
- EVAL: sample `q` and `state`. Go to WRITE only if `q`=00 and `state`=00; otherwise go to ERR.
- WRITE: `we`=1 and `data`=`jogador` for exactly one cycle, with the address held at `m_r`/`u_r`.
- SETTLE: drive `addr_macro`=`u_r`, `addr_micro`=0000. One cycle for the read and the board-state update.
- NEXT: set `next_macro` = `u_r` if `state`=00, else 0000. A closed target board gives free choice. The state of a board just won by the current write is already reflected here, because SETTLE separates the write from the sample.
- DONE: pulse `done`, toggle `jogador` (01↔10), increment `moves` (saturating at `MAX_MOVES`), return to IDLE.
- ERR: pulse `invalid`, return to IDLE. No write occurs, and `jogador`, `next_macro` and `moves` are unchanged.
- Output defaults: `we`=0 and `data`=00 outside WRITE. `addr_macro`/`addr_micro` = `m_r`/`u_r` in CHECK, READ, EVAL, WRITE and ERR; 0000 in IDLE; as specified in SETTLE, NEXT and DONE.
- Widths: `moves` is 7 bits. The compare against `MAX_MOVES` prevents wrap.

## Timing
- Reset values: `we`=0, `data`=00, `addr_macro`=0000, `addr_micro`=0000, `jogador`=01, `next_macro`=0000, `moves`=0, `busy`=0, `done`=0, `invalid`=0, FSM=IDLE.
- Cycle numbering: cycle 0 is the edge at which `jogar` is sampled in IDLE.
- Accepted move:
  - CHECK at 1, READ at 2, EVAL at 3.
  - `we` high during cycle 4.
  - SETTLE at 5; `next_macro` updated at the end of 6.
  - `done` high during cycle 7, with `jogador` and `moves` updated at the same edge.
  - Back in IDLE at 8; the next `jogar` is accepted from then on.
- Rejections:
  - Range or forced-macro violation: `invalid` high during cycle 2.
  - Occupied cell or closed board: `invalid` high during cycle 4, and `we` never asserts.
- `busy` is high from cycle 1 through the `done` or `invalid` cycle inclusive.
- `jogar` held high continuously: a new request is taken each time the FSM re-enters IDLE. Each accepted move produces one write.
- Reset asserted mid-operation: the FSM is in IDLE on the next cycle with all outputs at their reset values. If reset coincides with WRITE, `we` is 0 from the following cycle and the latched request is dropped.
- Simultaneous `reset` and `jogar`: reset wins and the request is dropped.

## Test plan
- Reset then `jogar` with macro 2 / micro 1 (board empty):
  - `we`=1 with `data`=01 at [0010][0001] in cycle 4.
  - `done` in cycle 7, `jogador`=10, `next_macro`=0001, `moves`=1.
- Replay the same coordinates in the forced board: macro 2 when `next_macro`=1 → `invalid` in cycle 2, no `we`. Then macro 1 / micro 1 → accepted with `data`=10.
- Occupied cell: write P1 at 1/5 and P2 at 5/1, then request 1/5 → `invalid` in cycle 4, `we` never high, `jogador` unchanged.
- Range: macro 0 or micro 10 → `invalid` in cycle 2. `moves` and `next_macro` unchanged.
- Closed-target rule:
  - Sequence P1 at 2/1, 2/2, 2/3 (interleaved legal P2 moves) closes board 2, with `state`=01.
  - A later move with micro 2 gives `next_macro`=0000.
  - Any move targeting macro 2 → `invalid` in cycle 4.
- Reset asserted during WRITE: `we` low on the next cycle, all outputs at reset values, `moves` returns to 0, `jogador`=01.
